// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the multi-channel line/word memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_RSVD = 2'b10,
    OP_WR   = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    STARTUP    = 4'd0,
    READY      = 4'd1,
    RD_REQ     = 4'd2,
    RD_LOAD    = 4'd3,
    FILL       = 4'd4,
    WR_COLLECT = 4'd5,
    WR_REQ     = 4'd6,
    WR_PUSH    = 4'd7,
    DONE       = 4'd8
  } state_t;

  // Number of words per cache line.
  function automatic int words_f(input int cl_width, input int word_width);
    return cl_width / word_width;
  endfunction

endpackage

// File: rtl/mem_ctrl_mc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the stored start pointer.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  input  logic              upd,
  input  logic [CH_W-1:0]   upd_idx,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [CH_W-1:0] ptr_r;
  int              cand_s;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt     = {NUM_CH{1'b0}};
    gnt_idx = {CH_W{1'b0}};
    gnt_vld = 1'b0;
    cand_s  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s = (int'(ptr_r) + i) % NUM_CH;
      if (en && !gnt_vld && req[cand_s]) begin
        gnt_vld        = 1'b1;
        gnt[cand_s]    = 1'b1;
        gnt_idx        = CH_W'(cand_s);
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

  // Pointer moves just past the channel that was served or rejected.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {CH_W{1'b0}};
    end else if (upd) begin
      if (int'(upd_idx) == NUM_CH - 1) ptr_r <= {CH_W{1'b0}};
      else                             ptr_r <= upd_idx + CH_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel line/word memory controller: round-robin word requesters onto one host line port.
// Optional alignment rejection with ch_err is enabled by defining MEM_CTRL_ALIGN_CHK_EN.
module mem_ctrl_mc
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int ADDR_BITCOUNT = 64,
  parameter int WORD_SIZE     = 32,
  parameter int CL_SIZE_WIDTH = 512,
  localparam int WORDS = words_f(CL_SIZE_WIDTH, WORD_SIZE),
  localparam int CNT_W = $clog2(WORDS),
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OFF_W = $clog2(CL_SIZE_WIDTH / 8)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   host_init,
  input  logic                                   host_rd_ready,
  input  logic                                   host_wr_ready,
  input  logic [CL_SIZE_WIDTH-1:0]               host_data_bus_read_in,
  output logic [CL_SIZE_WIDTH-1:0]               host_data_bus_write_out,
  output logic [ADDR_BITCOUNT-1:0]               corrected_address,
  output logic                                   host_re,
  output logic                                   host_we,
  input  logic [NUM_CH-1:0][1:0]                 ch_op,
  input  logic [NUM_CH-1:0][ADDR_BITCOUNT-1:0]   ch_raw_address,
  input  logic [NUM_CH-1:0][ADDR_BITCOUNT-1:0]   ch_address_offset,
  input  logic [NUM_CH-1:0][WORD_SIZE-1:0]       ch_wdata,
  output logic [NUM_CH-1:0]                      ch_grant,
  output logic [WORD_SIZE-1:0]                   ch_rdata,
  output logic                                   rd_valid,
  output logic [NUM_CH-1:0]                      tx_done,
  output logic                                   ready
`ifdef MEM_CTRL_ALIGN_CHK_EN
  ,
  output logic [NUM_CH-1:0]                      ch_err
`endif
);

  state_t                   state_r, next_s;
  logic [CH_W-1:0]          gnt_idx_r;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic [CL_SIZE_WIDTH-1:0] line_r;
  logic [NUM_CH-1:0]        req_s, arb_gnt_s;
  logic [CH_W-1:0]          arb_idx_s, upd_idx_s;
  logic                     arb_vld_s, upd_s, accept_s, reject_s, misalign_s, last_word_s;
  logic [ADDR_BITCOUNT-1:0] sel_addr_s;
  op_t                      sel_op_s;

  assign host_data_bus_write_out = line_r;

  // Request decode, selected-channel address and accept/reject decision.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      req_s[i] = (op_t'(ch_op[i]) == OP_RD) || (op_t'(ch_op[i]) == OP_WR);
    end
    sel_addr_s  = ch_raw_address[arb_idx_s] + ch_address_offset[arb_idx_s];
    sel_op_s    = op_t'(ch_op[arb_idx_s]);
`ifdef MEM_CTRL_ALIGN_CHK_EN
    misalign_s  = |sel_addr_s[OFF_W-1:0];
`else
    misalign_s  = 1'b0;
`endif
    accept_s    = arb_vld_s && !misalign_s;
    reject_s    = arb_vld_s && misalign_s;
    last_word_s = (cnt_r == CNT_W'(WORDS - 1));
    cnt_nxt_s   = last_word_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    upd_s       = (state_r == DONE) || reject_s;
    upd_idx_s   = (state_r == DONE) ? gnt_idx_r : arb_idx_s;
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_s),
    .en      (state_r == READY),
    .upd     (upd_s),
    .upd_idx (upd_idx_s),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      STARTUP:    next_s = host_init ? READY : STARTUP;
      READY: begin
        if (accept_s) next_s = (sel_op_s == OP_WR) ? WR_COLLECT : RD_REQ;
        else          next_s = READY;
      end
      RD_REQ:     next_s = host_rd_ready ? RD_LOAD : RD_REQ;
      RD_LOAD:    next_s = FILL;
      FILL:       next_s = last_word_s ? DONE : FILL;
      WR_COLLECT: next_s = last_word_s ? WR_REQ : WR_COLLECT;
      WR_REQ:     next_s = host_wr_ready ? WR_PUSH : WR_REQ;
      WR_PUSH:    next_s = DONE;
      DONE:       next_s = READY;
      default:    next_s = STARTUP;
    endcase
  end

  // State register and registered control outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= STARTUP;
      ready             <= 1'b0;
      host_re           <= 1'b0;
      host_we           <= 1'b0;
      rd_valid          <= 1'b0;
      tx_done           <= {NUM_CH{1'b0}};
      ch_grant          <= {NUM_CH{1'b0}};
      gnt_idx_r         <= {CH_W{1'b0}};
      corrected_address <= {ADDR_BITCOUNT{1'b0}};
    end else begin
      state_r  <= next_s;
      ready    <= (next_s == READY);
      host_re  <= (next_s == RD_LOAD);
      host_we  <= (next_s == WR_PUSH);
      rd_valid <= (next_s == FILL);
      tx_done  <= (next_s == DONE) ? ch_grant : {NUM_CH{1'b0}};
      if (accept_s) begin
        ch_grant          <= arb_gnt_s;
        gnt_idx_r         <= arb_idx_s;
        corrected_address <= sel_addr_s;
      end else if (state_r == DONE) begin
        ch_grant <= {NUM_CH{1'b0}};
      end else begin
        ch_grant <= ch_grant;
      end
    end
  end

  // Line buffer, word counter and registered read word (ch_rdata leads the counter by one).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      line_r   <= {CL_SIZE_WIDTH{1'b0}};
      ch_rdata <= {WORD_SIZE{1'b0}};
    end else begin
      case (state_r)
        RD_LOAD: begin
          line_r   <= host_data_bus_read_in;
          ch_rdata <= host_data_bus_read_in[WORD_SIZE-1:0];
        end
        FILL: begin
          cnt_r    <= cnt_nxt_s;
          ch_rdata <= line_r[int'(cnt_nxt_s)*WORD_SIZE +: WORD_SIZE];
        end
        WR_COLLECT: begin
          cnt_r <= cnt_nxt_s;
          line_r[int'(cnt_r)*WORD_SIZE +: WORD_SIZE] <= ch_wdata[gnt_idx_r];
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

`ifdef MEM_CTRL_ALIGN_CHK_EN
  // One-cycle error pulse for a rejected misaligned request.
  always_ff @(posedge clk) begin
    if (rst) ch_err <= {NUM_CH{1'b0}};
    else     ch_err <= reject_s ? arb_gnt_s : {NUM_CH{1'b0}};
  end
`endif

endmodule
